// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO register pair for the execute stage.
// Multiplies and HI/LO moves finish in the accept cycle; divides take 33 cycles via a restoring divider.
module md_unit_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        cancel,
  output logic        op_done,
  output logic [31:0] res_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [4:0] LastIter = 5'(DIV_ITERS - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [31:0] r_src1_raw;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div0;

  logic        w_op_mult;
  logic        w_op_multu;
  logic        w_op_div;
  logic        w_op_divu;
  logic        w_op_mfhi;
  logic        w_op_mflo;
  logic        w_op_mthi;
  logic        w_op_mtlo;
  logic        w_accept;
  logic        w_start_div;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;

  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  logic        w_wr_hi;
  logic        w_wr_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  // Fixed priority when more than one op bit is set: mult highest, mtlo lowest.
  always_comb begin
    w_op_mult  = 1'b0;
    w_op_multu = 1'b0;
    w_op_div   = 1'b0;
    w_op_divu  = 1'b0;
    w_op_mfhi  = 1'b0;
    w_op_mflo  = 1'b0;
    w_op_mthi  = 1'b0;
    w_op_mtlo  = 1'b0;
    if (req_op[7])      w_op_mult  = 1'b1;
    else if (req_op[6]) w_op_multu = 1'b1;
    else if (req_op[5]) w_op_div   = 1'b1;
    else if (req_op[4]) w_op_divu  = 1'b1;
    else if (req_op[3]) w_op_mfhi  = 1'b1;
    else if (req_op[2]) w_op_mflo  = 1'b1;
    else if (req_op[1]) w_op_mthi  = 1'b1;
    else if (req_op[0]) w_op_mtlo  = 1'b1;
  end

  assign req_ready   = (r_state == S_IDLE) && !cancel;
  assign w_accept    = req_valid && req_ready;
  assign w_start_div = w_accept && (w_op_div || w_op_divu);
  assign busy        = (r_state == S_DIV) || (r_state == S_DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;

  // Low 64 bits of a 64x64 product of sign-extended operands is the signed 32x32 product.
  assign w_prod_s = {{32{req_src1[31]}}, req_src1} * {{32{req_src2[31]}}, req_src2};
  assign w_prod_u = {32'd0, req_src1} * {32'd0, req_src2};

  assign w_a_neg = w_op_div && req_src1[31];
  assign w_b_neg = w_op_div && req_src2[31];
  assign w_a_abs = w_a_neg ? (32'd0 - req_src1) : req_src1;
  assign w_b_abs = w_b_neg ? (32'd0 - req_src2) : req_src2;

  // Restoring step: the dividend shifts out of r_quot as quotient bits shift in.
  assign w_rem_sh   = {r_rem, r_quot[31]};
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_rem_nxt  = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
  assign w_quot_nxt = {r_quot[30:0], ~w_diff[32]};

  assign w_q_fix = r_neg_q ? (32'd0 - r_quot) : r_quot;
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

  always_comb begin
    w_state_nxt = r_state;
    op_done     = 1'b0;
    res_data    = 32'd0;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_start_div) begin
          w_state_nxt = S_DIV;
        end else if (w_accept) begin
          op_done = 1'b1;
          if (w_op_mult) begin
            w_wr_hi  = 1'b1;
            w_wr_lo  = 1'b1;
            w_hi_nxt = w_prod_s[63:32];
            w_lo_nxt = w_prod_s[31:0];
          end else if (w_op_multu) begin
            w_wr_hi  = 1'b1;
            w_wr_lo  = 1'b1;
            w_hi_nxt = w_prod_u[63:32];
            w_lo_nxt = w_prod_u[31:0];
          end else if (w_op_mthi) begin
            w_wr_hi  = 1'b1;
            w_hi_nxt = req_src1;
          end else if (w_op_mtlo) begin
            w_wr_lo  = 1'b1;
            w_lo_nxt = req_src1;
          end else if (w_op_mfhi) begin
            res_data = r_hi;
          end else if (w_op_mflo) begin
            res_data = r_lo;
          end
        end
      end
      S_DIV: begin
        if (cancel)                  w_state_nxt = S_IDLE;
        else if (r_cnt == LastIter)  w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!cancel) begin
          op_done  = 1'b1;
          w_wr_hi  = 1'b1;
          w_wr_lo  = 1'b1;
          // Zero divisor: quotient all ones, remainder is the untouched dividend.
          w_hi_nxt = r_div0 ? r_src1_raw : w_r_fix;
          w_lo_nxt = r_div0 ? 32'hFFFF_FFFF : w_q_fix;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_cnt      <= 5'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_src1_raw <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
    end else begin
      if (w_wr_hi) r_hi <= w_hi_nxt;
      if (w_wr_lo) r_lo <= w_lo_nxt;
      if (w_start_div) begin
        r_quot     <= w_a_abs;
        r_divisor  <= w_b_abs;
        r_rem      <= 32'd0;
        r_cnt      <= 5'd0;
        r_src1_raw <= req_src1;
        r_neg_q    <= w_a_neg ^ w_b_neg;
        r_neg_r    <= w_a_neg;
        r_div0     <= (req_src2 == 32'd0);
      end else if (r_state == S_DIV) begin
        r_quot <= w_quot_nxt;
        r_rem  <= w_rem_nxt;
        r_cnt  <= r_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed plan steps followed by random ops against an arithmetic HI/LO model.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        cancel;
  logic        op_done;
  logic [31:0] res_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  md_unit_ctrl #(.DIV_ITERS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .cancel   (cancel),
    .op_done  (op_done),
    .res_data (res_data),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Index of the highest-priority op bit, -1 for an empty op.
  function automatic int top_bit(input logic [7:0] op);
    for (int i = 7; i >= 0; i--) if (op[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after completion.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int ev_at, input bit ev_rst, input bit hold, input logic [31:0] hd);
    int          t;
    logic [31:0] eq, er, exp_res;
    longint      sa, sb, ps;
    logic [63:0] pu;
    bit          evd;
    t   = top_bit(op);
    evd = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    if (t == 5 || t == 4) begin
      if (b == 32'd0) begin
        eq = 32'hFFFF_FFFF;
        er = a;
      end else if (t == 5) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eq = 32'(sa / sb);
        er = 32'(sa % sb);
      end else begin
        eq = a / b;
        er = a % b;
      end
      #3;
      chk("div_accept_ready", 32'(req_ready), 32'd1);
      chk("div_accept_done", 32'(op_done), 32'd0);
      tick();
      if (hold) begin
        req_op   = 8'h01;
        req_src1 = hd;
      end else begin
        req_valid = 1'b0;
        req_src1  = $urandom;
        req_src2  = $urandom;
      end
      for (int k = 1; k <= 33; k++) begin
        if (k == ev_at) begin
          if (ev_rst) reset = 1'b1;
          else        cancel = 1'b1;
        end
        #3;
        chk("div_busy", 32'(busy), 32'd1);
        chk("div_ready", 32'(req_ready), 32'd0);
        if (k == ev_at) begin
          if (!ev_rst) chk("div_cancel_done", 32'(op_done), 32'd0);
          tick();
          reset  = 1'b0;
          cancel = 1'b0;
          evd    = 1;
          if (ev_rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
          end
          break;
        end
        chk("div_done", 32'(op_done), (k == 33) ? 32'd1 : 32'd0);
        tick();
      end
      if (!evd) begin
        m_hi = er;
        m_lo = eq;
      end
      if (hold) begin
        #3;
        chk("held_ready", 32'(req_ready), 32'd1);
        chk("held_done", 32'(op_done), 32'd1);
        chk("held_div_hi", hi, m_hi);
        chk("held_div_lo", lo, m_lo);
        tick();
        req_valid = 1'b0;
        m_lo = hd;
      end else begin
        #1;
        chk("div_end_busy", 32'(busy), 32'd0);
        chk("div_end_ready", 32'(req_ready), 32'd1);
        chk("div_end_done", 32'(op_done), 32'd0);
        tick();
      end
      chk("div_hi", hi, m_hi);
      chk("div_lo", lo, m_lo);
    end else begin
      #3;
      exp_res = (t == 3) ? m_hi : (t == 2) ? m_lo : 32'd0;
      chk("op_ready", 32'(req_ready), 32'd1);
      chk("op_done", 32'(op_done), 32'd1);
      chk("op_res", res_data, exp_res);
      case (t)
        7: begin
          ps = longint'($signed(a)) * longint'($signed(b));
          {m_hi, m_lo} = ps;
        end
        6: begin
          pu = 64'(a) * 64'(b);
          {m_hi, m_lo} = pu;
        end
        1: m_hi = a;
        0: m_lo = a;
        default: ;
      endcase
      tick();
      req_valid = 1'b0;
      chk("op_hi", hi, m_hi);
      chk("op_lo", lo, m_lo);
    end
  endtask

  initial begin
    logic [7:0] op;
    int         ev;
    bit         evr;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 8'h00;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    cancel    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done", 32'(op_done), 32'd0);
    tick();

    do_op(8'h80, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
    chk("plan_mult_hi", hi, 32'hFFFF_FFFF);
    chk("plan_mult_lo", lo, 32'hFFFF_FFFA);
    do_op(8'h40, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
    chk("plan_multu_hi", hi, 32'h0000_0002);
    chk("plan_multu_lo", lo, 32'hFFFF_FFFA);

    do_op(8'h20, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    chk("plan_div_lo", lo, 32'hFFFF_FFFD);
    chk("plan_div_hi", hi, 32'hFFFF_FFFF);
    do_op(8'h10, 32'd7, 32'd2, 0, 0, 0, 0);
    chk("plan_divu_lo", lo, 32'd3);
    chk("plan_divu_hi", hi, 32'd1);
    do_op(8'h20, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("plan_ovf_lo", lo, 32'h8000_0000);
    chk("plan_ovf_hi", hi, 32'd0);
    do_op(8'h10, 32'd5, 32'd0, 0, 0, 0, 0);
    chk("plan_dz_lo", lo, 32'hFFFF_FFFF);
    chk("plan_dz_hi", hi, 32'd5);
    do_op(8'h20, 32'hFFFF_FFF0, 32'd0, 0, 0, 0, 0);
    chk("plan_sdz_hi", hi, 32'hFFFF_FFF0);

    do_op(8'h02, 32'h0000_AAAA, 32'd0, 0, 0, 0, 0);
    do_op(8'h20, 32'd100, 32'd7, 10, 0, 0, 0);
    do_op(8'h08, 32'd0, 32'd0, 0, 0, 0, 0);
    chk("plan_cancel_hi", hi, 32'h0000_AAAA);

    do_op(8'h02, 32'h0000_1234, 32'd0, 0, 0, 0, 0);
    do_op(8'h08, 32'd0, 32'd0, 0, 0, 0, 0);
    do_op(8'h10, 32'd40, 32'd6, 0, 0, 1, 32'h0000_5555);
    chk("plan_held_lo", lo, 32'h0000_5555);
    chk("plan_held_hi", hi, 32'd4);

    // Cancel while idle blocks the offered op.
    cancel    = 1'b1;
    req_valid = 1'b1;
    req_op    = 8'h02;
    req_src1  = 32'hDEAD_BEEF;
    #3;
    chk("idle_cancel_ready", 32'(req_ready), 32'd0);
    chk("idle_cancel_done", 32'(op_done), 32'd0);
    tick();
    cancel    = 1'b0;
    req_valid = 1'b0;
    chk("idle_cancel_hi", hi, m_hi);

    do_op(8'h00, 32'd9, 32'd9, 0, 0, 0, 0);
    do_op(8'h24, 32'd50, 32'd5, 33, 0, 0, 0);
    do_op(8'h10, 32'd50, 32'd5, 33, 1, 0, 0);
    chk("done_reset_lo", lo, 32'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: op = 8'h80;
        1: op = 8'h40;
        2, 3: op = 8'h20;
        4, 5: op = 8'h10;
        6: op = 8'h08;
        7: op = 8'h04;
        8: op = 8'h01 << $urandom_range(0, 1);
        default: op = 8'($urandom);
      endcase
      ev  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : 0;
      evr = (ev != 0) && ($urandom_range(0, 3) == 0);
      do_op(op, rv(), rv(), ev, evr, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
